ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction memory. It owns the program counter and drives the combinational imem address. It captures the returned instruction word with its PC into a 2-entry buffer and presents it to decode over a valid/ready handshake. It also handles redirects (branch/jump/trap targets) and flags misaligned or out-of-range fetch targets.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_DEPTH, 512, instruction memory size in 32-bit words; legal PCs satisfy PC[31:2] < IMEM_DEPTH

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_reset  input  1  asynchronous, active-low reset
i_redirect_valid  input  1  load i_redirect_pc into PC, flush buffer
i_redirect_pc  input  32  redirect target
o_imem_addr  output  32  fetch address to imem (= PC register, combinational)
i_imem_rdata  input  32  instruction word from imem, same-cycle
o_inst_valid  output  1  buffer head is valid
i_inst_ready  input  1  decode accepts head this cycle
o_inst  output  32  head instruction word
o_inst_pc  output  32  PC of head instruction
o_fault  output  1  sticky fetch fault
o_fault_cause  output  2  01 misaligned, 10 out-of-range, 00 none
o_fault_pc  output  32  offending PC

Behaviour:
- Reset (i_reset=0, async): PC=RESET_PC, state=IDLE, buffer count=0, o_inst_valid=0, o_inst=0, o_inst_pc=0, o_fault=0, o_fault_cause=00, o_fault_pc=0.
- FSM states IDLE, FETCH, FAULT.
  - IDLE: no fetch; goes to FETCH on the next edge.
  - FETCH: fetch each cycle allowed.
  - FAULT: no fetch; buffer still drains.
- Fetch condition: state=FETCH, no redirect, PC legal, and (count<2 or pop this cycle).
  - On fetch, push {i_imem_rdata, PC} and set PC <= PC+4.
  - Otherwise PC holds.
- Pop: o_inst_valid & i_inst_ready. Push and pop in the same cycle with count=2 is legal; count stays 2 and order is preserved.
- Latency: an instruction fetched in cycle N appears at the head in cycle N+1. Output fields are registered; no combinational path from i_imem_rdata to outputs.
- Legality check on the PC about to be fetched:
  - PC[1:0]!=0: cause 01.
  - PC[31:2]>=IMEM_DEPTH: cause 10.
  - Misaligned takes priority if both apply.
  - On an illegal PC in FETCH: no push; set o_fault=1, o_fault_cause, o_fault_pc=PC; go to FAULT. Already-buffered entries still drain normally.
- Redirect (highest priority, any state except IDLE):
  - Flush buffer (count=0, o_inst_valid=0 next cycle), even if a pop occurred the same cycle. No push that cycle.
  - PC <= i_redirect_pc.
  - Legal target: clear o_fault/o_fault_cause (o_fault_pc retains last value); state=FETCH.
  - Illegal target: go to or stay in FAULT, updating cause and fault_pc to the target.
  - A redirect in IDLE is ignored.
- PC+4 wraps modulo 2^32, but any wrapped value is out-of-range and faults.
- No deadlock: with i_inst_ready held low, PC and o_imem_addr stay stable. Buffer contents and outputs are held while o_inst_valid & !i_inst_ready.

Test Plan:
- Reset/stream: RESET_PC=0, imem[k]=0x00100013+k, ready=1, release reset -> o_inst_valid rises on 2nd rising edge after release; o_inst_pc=0,4,8,... on consecutive cycles with matching words, no gaps.
- Backpressure: ready=0 from first valid -> buffer holds pc 0,4; o_imem_addr stays 0x8; o_inst stable. Ready=1 -> 0,4,8,C delivered in order, none dropped or duplicated.
- Redirect flush: buffer full, redirect to 0x40 -> next cycle o_inst_valid=0. Following cycle o_inst_pc=0x40, o_inst=imem[16].
- Misaligned: redirect to 0x42 -> o_fault=1, cause=01, fault_pc=0x42, no valid output. Redirect to 0x10 -> fault clears, stream resumes from 0x10.
- Out-of-range: redirect to 0x7F8, ready=1 -> 0x7F8 and 0x7FC delivered, then o_fault=1, cause=10, fault_pc=0x800; o_imem_addr holds 0x800.
- Reset mid-operation: assert i_reset low asynchronously (between clock edges) with buffer full and fault set -> all outputs reach reset values immediately, before the next edge. Release -> restart from RESET_PC with identical timing to scenario 1.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, drives the imem address, and queues fetched
// words with their PCs in a 2-entry buffer toward decode, with redirect and fault handling.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 512
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_fault,
    output logic [1:0]  o_fault_cause,
    output logic [31:0] o_fault_pc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

    localparam logic [30:0] DEPTH_W    = 31'(IMEM_DEPTH);
    localparam logic [1:0]  CAUSE_NONE = 2'b00;
    localparam logic [1:0]  CAUSE_MIS  = 2'b01;
    localparam logic [1:0]  CAUSE_OOR  = 2'b10;

    // Misalignment wins over range; a PC reached by wrapping past 2^32 is never legal.
    function automatic logic [1:0] pc_cause(input logic [31:0] pc, input logic wrapped);
        logic [1:0] cause;
        if (pc[1:0] != 2'b00) begin
            cause = CAUSE_MIS;
        end else if (wrapped || ({1'b0, pc[31:2]} >= DEPTH_W)) begin
            cause = CAUSE_OOR;
        end else begin
            cause = CAUSE_NONE;
        end
        return cause;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        wrap_q, wrap_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_inst_q, head_inst_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] tail_inst_q, tail_inst_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic        redirect_s;
    logic        pop_s;
    logic        fetch_s;
    logic [1:0]  cur_cause_s;
    logic [1:0]  tgt_cause_s;
    logic [32:0] pc_inc_s;

    // Redirects only take effect once the fetch engine has left IDLE.
    always_comb begin
        redirect_s  = i_redirect_valid && (state_q != ST_IDLE);
        pop_s       = (count_q != 2'd0) && i_inst_ready;
        cur_cause_s = pc_cause(pc_q, wrap_q);
        tgt_cause_s = pc_cause(i_redirect_pc, 1'b0);
        pc_inc_s    = {1'b0, pc_q} + 33'd4;
        fetch_s     = (state_q == ST_FETCH) && !redirect_s && (cur_cause_s == CAUSE_NONE)
                      && ((count_q != 2'd2) || pop_s);
    end

    // Next-state, PC and fault register logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        wrap_d     = wrap_q;
        fault_d    = fault_q;
        cause_d    = cause_q;
        fault_pc_d = fault_pc_q;
        if (redirect_s) begin
            pc_d   = i_redirect_pc;
            wrap_d = 1'b0;
            if (tgt_cause_s == CAUSE_NONE) begin
                state_d = ST_FETCH;
                fault_d = 1'b0;
                cause_d = CAUSE_NONE;
            end else begin
                state_d    = ST_FAULT;
                fault_d    = 1'b1;
                cause_d    = tgt_cause_s;
                fault_pc_d = i_redirect_pc;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (cur_cause_s != CAUSE_NONE) begin
                        state_d    = ST_FAULT;
                        fault_d    = 1'b1;
                        cause_d    = cur_cause_s;
                        fault_pc_d = pc_q;
                    end else if (fetch_s) begin
                        pc_d   = pc_inc_s[31:0];
                        wrap_d = wrap_q | pc_inc_s[32];
                    end else begin
                        pc_d = pc_q;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Two-entry buffer: head feeds the outputs, tail backs it up when decode stalls.
    always_comb begin
        count_d     = count_q;
        head_inst_d = head_inst_q;
        head_pc_d   = head_pc_q;
        tail_inst_d = tail_inst_q;
        tail_pc_d   = tail_pc_q;
        if (redirect_s) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (fetch_s) begin
                        head_inst_d = i_imem_rdata;
                        head_pc_d   = pc_q;
                        count_d     = 2'd1;
                    end else begin
                        count_d = 2'd0;
                    end
                end
                2'd1: begin
                    if (fetch_s && pop_s) begin
                        head_inst_d = i_imem_rdata;
                        head_pc_d   = pc_q;
                    end else if (fetch_s) begin
                        tail_inst_d = i_imem_rdata;
                        tail_pc_d   = pc_q;
                        count_d     = 2'd2;
                    end else if (pop_s) begin
                        count_d = 2'd0;
                    end else begin
                        count_d = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_inst_d = tail_inst_q;
                        head_pc_d   = tail_pc_q;
                        if (fetch_s) begin
                            tail_inst_d = i_imem_rdata;
                            tail_pc_d   = pc_q;
                        end else begin
                            count_d = 2'd1;
                        end
                    end else begin
                        count_d = 2'd2;
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end
    end

    // State register bank.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            wrap_q      <= 1'b0;
            count_q     <= 2'd0;
            head_inst_q <= 32'h0000_0000;
            head_pc_q   <= 32'h0000_0000;
            tail_inst_q <= 32'h0000_0000;
            tail_pc_q   <= 32'h0000_0000;
            fault_q     <= 1'b0;
            cause_q     <= CAUSE_NONE;
            fault_pc_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            wrap_q      <= wrap_d;
            count_q     <= count_d;
            head_inst_q <= head_inst_d;
            head_pc_q   <= head_pc_d;
            tail_inst_q <= tail_inst_d;
            tail_pc_q   <= tail_pc_d;
            fault_q     <= fault_d;
            cause_q     <= cause_d;
            fault_pc_q  <= fault_pc_d;
        end
    end

    assign o_imem_addr   = pc_q;
    assign o_inst_valid  = (count_q != 2'd0);
    assign o_inst        = head_inst_q;
    assign o_inst_pc     = head_pc_q;
    assign o_fault       = fault_q;
    assign o_fault_cause = cause_q;
    assign o_fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: stream, backpressure, redirect flush, faults and async reset.
module tb_ifetch_unit;

    logic        i_clk;
    logic        i_reset;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_fault;
    logic [1:0]  o_fault_cause;
    logic [31:0] o_fault_pc;

    int checks;
    int failures;

    ifetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_DEPTH(512)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_redirect_valid(i_redirect_valid),
        .i_redirect_pc   (i_redirect_pc),
        .o_imem_addr     (o_imem_addr),
        .i_imem_rdata    (i_imem_rdata),
        .o_inst_valid    (o_inst_valid),
        .i_inst_ready    (i_inst_ready),
        .o_inst          (o_inst),
        .o_inst_pc       (o_inst_pc),
        .o_fault         (o_fault),
        .o_fault_cause   (o_fault_cause),
        .o_fault_pc      (o_fault_pc)
    );

    // imem[k] = 0x00100013 + k
    assign i_imem_rdata = 32'h0010_0013 + {2'b00, o_imem_addr[31:2]};

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge i_clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},    {31'd0, o_inst_valid}, 32'd0);
        chk({tag, "_inst"},     o_inst,                32'd0);
        chk({tag, "_inst_pc"},  o_inst_pc,             32'd0);
        chk({tag, "_fault"},    {31'd0, o_fault},      32'd0);
        chk({tag, "_cause"},    {30'd0, o_fault_cause}, 32'd0);
        chk({tag, "_fault_pc"}, o_fault_pc,            32'd0);
        chk({tag, "_addr"},     o_imem_addr,           32'd0);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'd0, o_inst_valid}, 32'd1);
        chk({tag, "_pc"},    o_inst_pc,             pc);
        chk({tag, "_inst"},  o_inst,                32'h0010_0013 + {2'b00, pc[31:2]});
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        i_reset          = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 32'd0;
        i_inst_ready     = 1'b1;

        // Reset state and streaming with ready held high
        cyc();
        cyc();
        chk_reset_outputs("rst");
        i_reset = 1'b1;
        cyc();
        chk("s1_idle_valid", {31'd0, o_inst_valid}, 32'd0);
        chk("s1_idle_addr", o_imem_addr, 32'd0);
        cyc();
        chk_head("s1_h0", 32'h0);
        chk("s1_addr4", o_imem_addr, 32'h4);
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk_head("s1_stream", 32'(k * 4));
        end

        // Backpressure from the first valid
        i_reset      = 1'b0;
        i_inst_ready = 1'b0;
        cyc();
        i_reset = 1'b1;
        cyc();
        cyc();
        chk_head("s2_h0", 32'h0);
        cyc();
        chk("s2_addr8a", o_imem_addr, 32'h8);
        chk_head("s2_hold_a", 32'h0);
        cyc();
        chk("s2_addr8b", o_imem_addr, 32'h8);
        chk_head("s2_hold_b", 32'h0);
        i_inst_ready = 1'b1;
        cyc();
        chk_head("s2_d4", 32'h4);
        cyc();
        chk_head("s2_d8", 32'h8);
        cyc();
        chk_head("s2_dC", 32'hC);

        // Redirect flush with a full buffer
        i_inst_ready     = 1'b0;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h40;
        cyc();
        chk("s3_flush_valid", {31'd0, o_inst_valid}, 32'd0);
        chk("s3_addr", o_imem_addr, 32'h40);
        i_redirect_valid = 1'b0;
        cyc();
        chk_head("s3_h40", 32'h40);
        chk("s3_inst_word", o_inst, 32'h0010_0023);

        // Misaligned redirect, then recovery
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h42;
        cyc();
        chk("s4_fault", {31'd0, o_fault}, 32'd1);
        chk("s4_cause", {30'd0, o_fault_cause}, 32'd1);
        chk("s4_fault_pc", o_fault_pc, 32'h42);
        chk("s4_valid", {31'd0, o_inst_valid}, 32'd0);
        chk("s4_addr", o_imem_addr, 32'h42);
        i_redirect_valid = 1'b0;
        i_inst_ready     = 1'b1;
        cyc();
        chk("s4_hold_valid", {31'd0, o_inst_valid}, 32'd0);
        chk("s4_hold_fault", {31'd0, o_fault}, 32'd1);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h10;
        cyc();
        chk("s4_clr_fault", {31'd0, o_fault}, 32'd0);
        chk("s4_clr_cause", {30'd0, o_fault_cause}, 32'd0);
        chk("s4_keep_fault_pc", o_fault_pc, 32'h42);
        chk("s4_clr_valid", {31'd0, o_inst_valid}, 32'd0);
        i_redirect_valid = 1'b0;
        cyc();
        chk_head("s4_h10", 32'h10);
        cyc();
        chk_head("s4_h14", 32'h14);

        // Out-of-range after the last legal words
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h7F8;
        cyc();
        chk("s5_flush_valid", {31'd0, o_inst_valid}, 32'd0);
        i_redirect_valid = 1'b0;
        cyc();
        chk_head("s5_h7F8", 32'h7F8);
        chk("s5_word510", o_inst, 32'h0010_0211);
        cyc();
        chk_head("s5_h7FC", 32'h7FC);
        chk("s5_no_fault_yet", {31'd0, o_fault}, 32'd0);
        cyc();
        chk("s5_valid", {31'd0, o_inst_valid}, 32'd0);
        chk("s5_fault", {31'd0, o_fault}, 32'd1);
        chk("s5_cause", {30'd0, o_fault_cause}, 32'd2);
        chk("s5_fault_pc", o_fault_pc, 32'h800);
        chk("s5_addr", o_imem_addr, 32'h800);
        cyc();
        chk("s5_addr_hold", o_imem_addr, 32'h800);

        // Async reset with full buffer and fault pending
        i_inst_ready     = 1'b0;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h7F8;
        cyc();
        i_redirect_valid = 1'b0;
        cyc();
        cyc();
        cyc();
        chk_head("s6_full_head", 32'h7F8);
        chk("s6_fault", {31'd0, o_fault}, 32'd1);
        chk("s6_addr", o_imem_addr, 32'h800);
        #2;
        i_reset = 1'b0;
        #1;
        chk_reset_outputs("s6_async");
        cyc();
        i_reset      = 1'b1;
        i_inst_ready = 1'b1;
        cyc();
        chk("s6_idle_valid", {31'd0, o_inst_valid}, 32'd0);
        cyc();
        chk_head("s6_h0", 32'h0);
        cyc();
        chk_head("s6_h4", 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
